mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_if.sv | 23 ++
 rtl/mem_stage.sv | 184 ++++++++++++++++++
 tb/tb_mem_stage.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage and the data memory.
//   master (mem_stage side): drives dmem_req, dmem_we, dmem_addr, dmem_wdata,
//                            dmem_be; samples dmem_rdata, dmem_ack
//   slave  (memory side)   : the mirror image
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: performs byte/half/word loads and stores over a
// req/ack data-memory bus and registers the result towards write-back.
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid, in_*    : operands from execute (held stable while stall=1)
//   stall             : back-pressure to upstream
//   dmem              : data-memory bus (master side)
//   instruction .. D_out, wb_sel_out, wb_valid, misalign_exc : registered WB side
module mem_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        stall,
  input  logic [31:0] in_instruction,
  input  logic [31:0] in_PCadd4,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_rs2_data,
  input  logic [31:0] in_immediate,
  input  logic [1:0]  in_wb_sel,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  mem_stage_if.master dmem,
  output logic [31:0] instruction,
  output logic [31:0] PCadd4,
  output logic [31:0] alu_result,
  output logic [31:0] immediate,
  output logic [31:0] D_out,
  output logic [1:0]  wb_sel_out,
  output logic        wb_valid,
  output logic        misalign_exc
);

  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_next;

  logic [2:0]  funct3;
  logic [1:0]  addr_lo;
  logic        mem_op, bad_op, misaligned;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  logic [31:0] instruction_d, PCadd4_d, alu_result_d, immediate_d, D_out_d;
  logic [1:0]  wb_sel_d;
  logic        wb_valid_d, misalign_d;

  assign funct3  = in_instruction[14:12];
  assign addr_lo = in_alu_result[1:0];
  assign mem_op  = in_mem_read | in_mem_write;

  // Unsigned sizes exist only for loads; unknown funct3 is treated as misaligned.
  always_comb begin
    bad_op = 1'b0;
    unique case (funct3)
      3'b000:  bad_op = 1'b0;
      3'b001:  bad_op = addr_lo[0];
      3'b010:  bad_op = (addr_lo != 2'b00);
      3'b100:  bad_op = in_mem_write;
      3'b101:  bad_op = addr_lo[0] | in_mem_write;
      default: bad_op = 1'b1;
    endcase
  end
  assign misaligned = mem_op & bad_op;

  assign ld_byte = dmem.dmem_rdata[{addr_lo, 3'b000} +: 8];
  assign ld_half = addr_lo[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];

  always_comb begin
    ld_data = dmem.dmem_rdata;
    unique case (funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = dmem.dmem_rdata;
    endcase
  end

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (in_valid && mem_op && !misaligned) state_next = ACCESS;
      ACCESS: if (dmem.dmem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: bus, stall and next WB values
  always_comb begin
    stall           = 1'b0;
    dmem.dmem_req   = 1'b0;
    dmem.dmem_we    = 1'b0;
    dmem.dmem_be    = '0;
    dmem.dmem_addr  = {in_alu_result[31:2], 2'b00};
    dmem.dmem_wdata = in_rs2_data;

    instruction_d = NOP_INSTR;
    PCadd4_d      = '0;
    alu_result_d  = '0;
    immediate_d   = '0;
    D_out_d       = '0;
    wb_sel_d      = '0;
    wb_valid_d    = 1'b0;
    misalign_d    = 1'b0;

    unique case (state)
      IDLE: begin
        if (in_valid) begin
          if (misaligned) begin
            misalign_d = 1'b1;
          end else if (mem_op) begin
            stall = !rst;
          end else begin
            instruction_d = in_instruction;
            PCadd4_d      = in_PCadd4;
            alu_result_d  = in_alu_result;
            immediate_d   = in_immediate;
            wb_sel_d      = in_wb_sel;
            wb_valid_d    = 1'b1;
          end
        end
      end
      ACCESS: begin
        stall         = !dmem.dmem_ack;
        dmem.dmem_req = 1'b1;
        dmem.dmem_we  = in_mem_write;
        unique case (funct3[1:0])
          2'b00: begin
            dmem.dmem_be    = 4'b0001 << addr_lo;
            dmem.dmem_wdata = {4{in_rs2_data[7:0]}};
          end
          2'b01: begin
            dmem.dmem_be    = 4'b0011 << {addr_lo[1], 1'b0};
            dmem.dmem_wdata = {2{in_rs2_data[15:0]}};
          end
          default: dmem.dmem_be = 4'b1111;
        endcase
        if (dmem.dmem_ack) begin
          instruction_d = in_instruction;
          if (in_mem_write) instruction_d[11:7] = 5'd0;
          PCadd4_d     = in_PCadd4;
          alu_result_d = in_alu_result;
          immediate_d  = in_immediate;
          wb_sel_d     = in_wb_sel;
          D_out_d      = in_mem_write ? 32'd0 : ld_data;
          wb_valid_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // WB-side pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction  <= NOP_INSTR;
      PCadd4       <= '0;
      alu_result   <= '0;
      immediate    <= '0;
      D_out        <= '0;
      wb_sel_out   <= '0;
      wb_valid     <= 1'b0;
      misalign_exc <= 1'b0;
    end else begin
      instruction  <= instruction_d;
      PCadd4       <= PCadd4_d;
      alu_result   <= alu_result_d;
      immediate    <= immediate_d;
      D_out        <= D_out_d;
      wb_sel_out   <= wb_sel_d;
      wb_valid     <= wb_valid_d;
      misalign_exc <= misalign_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [31:0] I_ADD  = 32'h0020_82B3;
  localparam logic [31:0] I_ORI  = 32'h0FF0_E513;
  localparam logic [31:0] I_LW   = 32'h0000_2303;
  localparam logic [31:0] I_LH   = 32'h0000_1383;
  localparam logic [31:0] I_LB   = 32'h0000_0403;
  localparam logic [31:0] I_LBU  = 32'h0000_4583;
  localparam logic [31:0] I_LHU  = 32'h0000_5483;
  localparam logic [31:0] I_LH2  = 32'h0000_1603;
  localparam logic [31:0] I_LX3  = 32'h0000_3303;
  localparam logic [31:0] I_SW   = 32'h0000_2423;
  localparam logic [31:0] I_SH   = 32'h0000_1FA3;
  localparam logic [31:0] I_SB   = 32'h0000_01A3;
  localparam logic [31:0] I_SX4  = 32'h0000_4423;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, stall;
  logic [31:0] in_instruction, in_PCadd4, in_alu_result, in_rs2_data, in_immediate;
  logic [1:0]  in_wb_sel;
  logic        in_mem_read, in_mem_write;
  logic [31:0] instruction, PCadd4, alu_result, immediate, D_out;
  logic [1:0]  wb_sel_out;
  logic        wb_valid, misalign_exc;

  mem_stage_if dmem_bus ();

  mem_stage #(.NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall),
    .in_instruction(in_instruction), .in_PCadd4(in_PCadd4),
    .in_alu_result(in_alu_result), .in_rs2_data(in_rs2_data),
    .in_immediate(in_immediate), .in_wb_sel(in_wb_sel),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .dmem(dmem_bus.master),
    .instruction(instruction), .PCadd4(PCadd4), .alu_result(alu_result),
    .immediate(immediate), .D_out(D_out), .wb_sel_out(wb_sel_out),
    .wb_valid(wb_valid), .misalign_exc(misalign_exc)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        valid;
    logic [31:0] instr, pc4, alu, imm;
    logic [1:0]  wsel;
    logic        rd, wr;
    logic        e_wbv, e_mis;
    logic [31:0] e_instr, e_pc4, e_alu, e_imm;
    logic [1:0]  e_wsel;
  } vec_t;

  vec_t vecs[10];

  // Full load/store transaction with 'waits' ack-less cycles in ACCESS.
  task automatic mem_op(input string nm, input logic [31:0] instr, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [31:0] rdata, input logic is_st,
                        input int unsigned waits, input logic [3:0] e_be,
                        input logic [31:0] e_wdata, input logic [31:0] e_dout);
    int unsigned stalls;
    logic [31:0] e_instr;
    e_instr = instr;
    if (is_st) e_instr[11:7] = 5'd0;
    stalls = 0;
    in_valid = 1'b1; in_instruction = instr; in_alu_result = addr;
    in_rs2_data = rs2; in_immediate = 32'h44; in_PCadd4 = 32'h200; in_wb_sel = 2'b01;
    in_mem_read = !is_st; in_mem_write = is_st;
    dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = 32'hDEAD_0000;
    #1;
    if (stall) stalls++;
    chk({nm, " req_idle"}, {31'd0, dmem_bus.dmem_req}, 32'd0);
    tick();
    chk({nm, " bubble_on_entry"}, {31'd0, wb_valid}, 32'd0);
    for (int unsigned w = 0; w < waits; w++) begin
      if (stall) stalls++;
      chk({nm, " req_wait"}, {31'd0, dmem_bus.dmem_req}, 32'd1);
      tick();
    end
    dmem_bus.dmem_rdata = rdata;
    dmem_bus.dmem_ack = 1'b1;
    #1;
    if (stall) stalls++;
    chk({nm, " req_ack"}, {31'd0, dmem_bus.dmem_req}, 32'd1);
    chk({nm, " addr"}, dmem_bus.dmem_addr, {addr[31:2], 2'b00});
    chk({nm, " we"}, {31'd0, dmem_bus.dmem_we}, {31'd0, is_st});
    if (is_st) begin
      chk({nm, " be"}, {28'd0, dmem_bus.dmem_be}, {28'd0, e_be});
      chk({nm, " wdata"}, dmem_bus.dmem_wdata, e_wdata);
    end
    tick();
    dmem_bus.dmem_ack = 1'b0;
    in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
    chk({nm, " wb_valid"}, {31'd0, wb_valid}, 32'd1);
    chk({nm, " D_out"}, D_out, e_dout);
    chk({nm, " instr"}, instruction, e_instr);
    chk({nm, " alu"}, alu_result, addr);
    chk({nm, " stall_cycles"}, stalls, waits + 1);
    #1;
    chk({nm, " req_after"}, {31'd0, dmem_bus.dmem_req}, 32'd0);
    tick();
    chk({nm, " wb_valid_after"}, {31'd0, wb_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_instruction = '0; in_PCadd4 = '0; in_alu_result = '0;
    in_rs2_data = '0; in_immediate = '0; in_wb_sel = '0;
    in_mem_read = 1'b0; in_mem_write = 1'b0;
    dmem_bus.dmem_rdata = '0; dmem_bus.dmem_ack = 1'b0;

    //           valid instr   pc4        alu           imm        wsel  rd wr  wbv mis e_instr e_pc4      e_alu         e_imm      e_wsel
    vecs[0] = '{1'b1, I_ADD, 32'h104, 32'h55,        32'h10,    2'd1, 0, 0, 1, 0, I_ADD, 32'h104, 32'h55,        32'h10,    2'd1};
    vecs[1] = '{1'b0, I_ADD, 32'h108, 32'h77,        32'h20,    2'd1, 0, 0, 0, 0, NOP,   32'h0,   32'h0,         32'h0,     2'd0};
    vecs[2] = '{1'b1, I_LW,  32'h10C, 32'h3001,      32'h1,     2'd2, 1, 0, 0, 1, NOP,   32'h0,   32'h0,         32'h0,     2'd0};
    vecs[3] = '{1'b1, I_ADD, 32'h110, 32'hDEAD_BEEF, 32'h30,    2'd3, 0, 0, 1, 0, I_ADD, 32'h110, 32'hDEAD_BEEF, 32'h30,    2'd3};
    vecs[4] = '{1'b1, I_LH,  32'h114, 32'h0001,      32'h0,     2'd2, 1, 0, 0, 1, NOP,   32'h0,   32'h0,         32'h0,     2'd0};
    vecs[5] = '{1'b1, I_SW,  32'h118, 32'h0002,      32'h0,     2'd0, 0, 1, 0, 1, NOP,   32'h0,   32'h0,         32'h0,     2'd0};
    vecs[6] = '{1'b1, I_LX3, 32'h11C, 32'h0000,      32'h0,     2'd2, 1, 0, 0, 1, NOP,   32'h0,   32'h0,         32'h0,     2'd0};
    vecs[7] = '{1'b1, I_SX4, 32'h120, 32'h0000,      32'h0,     2'd0, 0, 1, 0, 1, NOP,   32'h0,   32'h0,         32'h0,     2'd0};
    vecs[8] = '{1'b0, I_LW,  32'h124, 32'h0000,      32'h0,     2'd2, 1, 0, 0, 0, NOP,   32'h0,   32'h0,         32'h0,     2'd0};
    vecs[9] = '{1'b1, I_ORI, 32'h128, 32'hFFFF_0000, 32'hFF,    2'd1, 0, 0, 1, 0, I_ORI, 32'h128, 32'hFFFF_0000, 32'hFF,    2'd1};

    tick(); tick();
    chk("rst instr", instruction, NOP);
    chk("rst wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst misalign", {31'd0, misalign_exc}, 32'd0);
    chk("rst D_out", D_out, 32'd0);
    chk("rst stall", {31'd0, stall}, 32'd0);
    chk("rst req", {31'd0, dmem_bus.dmem_req}, 32'd0);
    rst = 1'b0;
    tick();

    // Single-cycle paths; a stray ack is held high to show it is ignored in IDLE.
    for (int i = 0; i < 10; i++) begin
      in_valid = vecs[i].valid; in_instruction = vecs[i].instr; in_PCadd4 = vecs[i].pc4;
      in_alu_result = vecs[i].alu; in_immediate = vecs[i].imm; in_wb_sel = vecs[i].wsel;
      in_rs2_data = 32'h1234_5678;
      in_mem_read = vecs[i].rd; in_mem_write = vecs[i].wr;
      dmem_bus.dmem_ack = 1'b1;
      #1;
      chk($sformatf("v%0d stall", i), {31'd0, stall}, 32'd0);
      chk($sformatf("v%0d req", i), {31'd0, dmem_bus.dmem_req}, 32'd0);
      tick();
      chk($sformatf("v%0d wb_valid", i), {31'd0, wb_valid}, {31'd0, vecs[i].e_wbv});
      chk($sformatf("v%0d misalign", i), {31'd0, misalign_exc}, {31'd0, vecs[i].e_mis});
      chk($sformatf("v%0d instr", i), instruction, vecs[i].e_instr);
      chk($sformatf("v%0d pc4", i), PCadd4, vecs[i].e_pc4);
      chk($sformatf("v%0d alu", i), alu_result, vecs[i].e_alu);
      chk($sformatf("v%0d imm", i), immediate, vecs[i].e_imm);
      chk($sformatf("v%0d wsel", i), {30'd0, wb_sel_out}, {30'd0, vecs[i].e_wsel});
      chk($sformatf("v%0d D_out", i), D_out, 32'd0);
    end
    in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
    dmem_bus.dmem_ack = 1'b0;
    tick();
    chk("misalign one cycle", {31'd0, misalign_exc}, 32'd0);

    mem_op("LB",  I_LB,  32'h1003, 32'h0,         32'h80FF_FF7F, 1'b0, 3, 4'b0000, 32'h0,         32'hFFFF_FF80);
    mem_op("SH",  I_SH,  32'h2002, 32'h1234_ABCD, 32'h0,         1'b1, 0, 4'b1100, 32'hABCD_ABCD, 32'h0);
    mem_op("SW",  I_SW,  32'h5004, 32'hCAFE_BABE, 32'h0,         1'b1, 1, 4'b1111, 32'hCAFE_BABE, 32'h0);
    mem_op("SB",  I_SB,  32'h6001, 32'h0000_00A5, 32'h0,         1'b1, 0, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    mem_op("LBU", I_LBU, 32'h7002, 32'h0,         32'h11F2_3344, 1'b0, 2, 4'b0000, 32'h0,         32'h0000_00F2);
    mem_op("LH",  I_LH2, 32'h8002, 32'h0,         32'h9ABC_1234, 1'b0, 0, 4'b0000, 32'h0,         32'hFFFF_9ABC);
    mem_op("LW",  I_LW,  32'h9000, 32'h0,         32'h7654_3210, 1'b0, 1, 4'b0000, 32'h0,         32'h7654_3210);

    // Reset in the middle of an LHU access.
    in_valid = 1'b1; in_instruction = I_LHU; in_alu_result = 32'h4002; in_PCadd4 = 32'h300;
    in_immediate = 32'h0; in_wb_sel = 2'b01; in_mem_read = 1'b1; in_mem_write = 1'b0;
    dmem_bus.dmem_rdata = 32'h8001_0000; dmem_bus.dmem_ack = 1'b0;
    #1;
    chk("rstacc stall_idle", {31'd0, stall}, 32'd1);
    tick();
    chk("rstacc req", {31'd0, dmem_bus.dmem_req}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstacc req_drop", {31'd0, dmem_bus.dmem_req}, 32'd0);
    chk("rstacc stall", {31'd0, stall}, 32'd0);
    chk("rstacc wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rstacc instr", instruction, NOP);
    tick();
    rst = 1'b0; in_valid = 1'b0; in_mem_read = 1'b0;
    dmem_bus.dmem_ack = 1'b1;
    tick();
    chk("rstacc no_result", {31'd0, wb_valid}, 32'd0);
    chk("rstacc idle_req", {31'd0, dmem_bus.dmem_req}, 32'd0);
    dmem_bus.dmem_ack = 1'b0;
    tick();

    mem_op("LHU", I_LHU, 32'h4002, 32'h0, 32'h8001_0000, 1'b0, 1, 4'b0000, 32'h0, 32'h0000_8001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
